// File: rtl/fp_result_pack.sv
// fp_result_pack: back end of the binary32 adder. Normalises the raw sum,
// rounds to nearest-even, handles subnormals and packs the IEEE-754 word.
// Optional build macro: FP_PACK_FTZ_EN (flush subnormal results to zero).
//
// state | meaning
// IDLE  | ready for a new tuple
// ALIGN | special bypass, carry-out fix-up or zero detect
// NORM  | one left shift per cycle until hidden bit set or exp==1
// ROUND | round-to-nearest-even and pack
// DONE  | result valid, held until out_ready
module fp_result_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mant,
    input  logic [1:0]  in_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_err,
    output logic        out_inexact
);

    localparam logic [1:0] NO_ERR   = 2'd0;
    localparam logic [1:0] ZERO_ERR = 2'd1;
    localparam logic [1:0] NAN_ERR  = 2'd2;
    localparam logic [1:0] INF_ERR  = 2'd3;

    typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, DONE} state_t;

    state_t      state, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [27:0] mant_q, mant_d;
    logic [1:0]  err_q, err_d;
    logic [4:0]  shcnt_q, shcnt_d;
    logic [31:0] res_d;
    logic [1:0]  oerr_d;
    logic        inex_d;

    logic [8:0]  exp_inc;
    logic        rnd_inc;
    logic [24:0] rnd_sum;
    logic [7:0]  pk_exp;
    logic [22:0] pk_frac;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Rounding datapath shared by ALIGN (carry fix-up) and ROUND
    always_comb begin
        exp_inc = {1'b0, exp_q} + 9'd1;
        rnd_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        rnd_sum = {1'b0, mant_q[26:3]} + {24'd0, rnd_inc};
        pk_exp  = rnd_sum[23] ? exp_q : 8'd0;
        pk_frac = rnd_sum[22:0];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        err_d   = err_q;
        shcnt_d = shcnt_q;
        res_d   = out_result;
        oerr_d  = out_err;
        inex_d  = out_inexact;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    err_d   = in_err;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (err_q != NO_ERR) begin
                    case (err_q)
                        ZERO_ERR: res_d = 32'h0000_0000;
                        NAN_ERR:  res_d = 32'h7FC0_0000;
                        default:  res_d = {sign_q, 8'hFF, 23'd0};
                    endcase
                    oerr_d  = err_q;
                    inex_d  = 1'b0;
                    state_d = DONE;
                end else if (mant_q[27]) begin
                    if (exp_inc >= 9'd255) begin
                        res_d   = {sign_q, 8'hFF, 23'd0};
                        oerr_d  = INF_ERR;
                        inex_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        exp_d   = exp_inc[7:0];
                        mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                        state_d = ROUND;
                    end
                end else if (mant_q == 28'd0) begin
                    res_d   = {sign_q, 31'd0};
                    oerr_d  = ZERO_ERR;
                    inex_d  = 1'b0;
                    state_d = DONE;
                end else if (!mant_q[26] && exp_q > 8'd1) begin
                    shcnt_d = 5'd25;
                    state_d = NORM;
                end else begin
                    state_d = ROUND;
                end
            end
            NORM: begin
                mant_d  = {mant_q[26:0], 1'b0};
                exp_d   = exp_q - 8'd1;
                shcnt_d = shcnt_q - 5'd1;
                // Exit decided on the post-shift values; the counter bounds the walk
                if (mant_q[25] || exp_q == 8'd2 || shcnt_q == 5'd1)
                    state_d = ROUND;
            end
            ROUND: begin
                inex_d  = |mant_q[2:0];
                oerr_d  = NO_ERR;
                state_d = DONE;
                if (rnd_sum[24]) begin
                    if (exp_inc >= 9'd255) begin
                        res_d  = {sign_q, 8'hFF, 23'd0};
                        oerr_d = INF_ERR;
                    end else begin
                        res_d  = {sign_q, exp_inc[7:0], rnd_sum[23:1]};
                    end
                end else if (pk_exp == 8'd0 && pk_frac == 23'd0) begin
                    res_d  = {sign_q, 31'd0};
                    oerr_d = ZERO_ERR;
                end else if (pk_exp == 8'd0) begin
`ifdef FP_PACK_FTZ_EN
                    res_d  = {sign_q, 31'd0};
                    oerr_d = ZERO_ERR;
                    inex_d = 1'b1;
`else
                    res_d  = {sign_q, 8'd0, pk_frac};
`endif
                end else begin
                    res_d  = {sign_q, pk_exp, pk_frac};
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= 8'd0;
            mant_q      <= 28'd0;
            err_q       <= NO_ERR;
            shcnt_q     <= 5'd0;
            out_result  <= 32'd0;
            out_err     <= NO_ERR;
            out_inexact <= 1'b0;
        end else begin
            state       <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            err_q       <= err_d;
            shcnt_q     <= shcnt_d;
            out_result  <= res_d;
            out_err     <= oerr_d;
            out_inexact <= inex_d;
        end
    end

endmodule

// File: doc/fp_result_pack.md
# fp_result_pack

Back-end stage of the single-precision FP adder. It takes the raw sum (sign, biased exponent, extended mantissa) and the special-case class produced by the front-end operand screen. It normalises the sum iteratively, rounds round-to-nearest-even, handles subnormal results, and packs the final IEEE-754 word. Input and output each use a valid/ready handshake, so the block can sit between the adder datapath and the writeback register.

## Interface
- No parameters; widths are fixed to binary32.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input tuple valid
- in_ready  out  1  block can accept; high only in IDLE
- in_sign  in  1  result sign
- in_exp  in  8  biased exponent; subnormal operands already forced to 1 upstream
- in_mant  in  28  [27] carry-out, [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky
- in_err  in  2  addpkg::i_err_t special class: NO_ERR=0, ZERO_ERR=1, NAN_ERR=2, INF_ERR=3
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts
- out_result  out  32  packed IEEE-754 word
- out_err  out  2  final class (i_err_t); INF_ERR also on exponent overflow
- out_inexact  out  1  any G/R/S bit nonzero before rounding, or flush occurred

## Operation
- States: IDLE, ALIGN, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, latch all inputs and go to ALIGN.
- ALIGN, special input (in_err != NO_ERR): pack directly, then go to DONE.
  - ZERO_ERR gives 32'h0000_0000.
  - NAN_ERR gives 32'h7FC0_0000.
  - INF_ERR gives {sign, 8'hFF, 23'b0}.
  - out_err = latched err; out_inexact = 0.
- ALIGN, mant[27]=1: shift mant right 1 with sticky = S | shifted-out bit; exp+1.
  - If exp reaches 255, output INF: {sign, FF, 0}, out_err=INF_ERR, out_inexact=1. Go to DONE.
- ALIGN, mant==0: output {sign, 31'b0}, out_err=ZERO_ERR. Go to DONE.
- ALIGN, otherwise: go to NORM if mant[26]=0 and exp>1; else go to ROUND.
- NORM: one left shift per cycle (zero fill), exp-1.
  - Stays in NORM while mant[26]=0 and exp>1.
  - Exits to ROUND on mant[26]=1 or exp==1.
  - At most 25 shifts.
- ROUND (RNE): inc = G & (R | S | mant[3]); fraction field {mant[26:3]} + inc.
  - Carry into bit 27: shift right, exp+1. If exp reaches 255, output INF with out_err=INF_ERR.
  - Pack: if mant[26]=0 (subnormal), exponent field = 0; else exponent field = exp. Fraction field = mant[25:3].
  - A subnormal that rounds up into bit 26 packs with exponent field 1.
  - Result with exponent field 0 and zero fraction gives out_err=ZERO_ERR; otherwise NO_ERR.
- DONE: out_valid=1. out_* are stable while out_valid is high. On out_ready, go to IDLE. No same-cycle re-accept.

## Timing
- Input accepted at cycle T (edge ending T). State is ALIGN in T+1.
- Special or zero result: out_valid in T+2.
- Normal result with k normalisation shifts: out_valid in T+3+k.
- Throughput: one result per latency+1 cycles, at minimum.
- Reset (any state, including mid-NORM) forces:
  - state=IDLE, in_ready=1 (after reset)
  - out_valid=0, out_result=0, out_err=NO_ERR, out_inexact=0
  - internal registers cleared; in-flight result is discarded.
- out_valid=1 with out_ready=0: all outputs hold indefinitely; in_ready stays 0.

## Configuration
- FP_PACK_FTZ_EN defined (flush-to-zero):
  - Any result that would pack with exponent field 0 and nonzero fraction outputs {sign, 31'b0}.
  - out_err=ZERO_ERR, out_inexact=1.
  - NORM still runs, so latency is unchanged.
- FP_PACK_FTZ_EN undefined: gradual underflow as described above.

## Test plan
- Special bypass: in_err=NAN_ERR, any data -> out_result=32'h7FC0_0000, out_valid at T+2. in_err=INF_ERR, sign=1 -> 32'hFF80_0000.
- Already normal: sign=0, exp=8'h7F, mant=28'h400_0000 -> 32'h3F80_0000, out_valid at T+3, inexact=0. Carry case mant=28'h800_0000 -> 32'h4000_0000.
- Normalise: exp=8'h7F, mant=28'h100_0000 -> 2 shifts, 32'h3E80_0000, out_valid at T+5.
- Ties-to-even: exp=8'h7F, mant=28'h400_000C (LSB=1, G=1) -> 32'h3F80_0002, inexact=1. Overflow: exp=8'hFE, mant=28'hFFF_FFFC -> 32'h7F80_0000, out_err=INF_ERR.
- Subnormal: exp=1, mant=28'h200_0000 -> 32'h0040_0000 (FP_PACK_FTZ_EN undefined). With FP_PACK_FTZ_EN defined -> 32'h0000_0000, out_err=ZERO_ERR.
- Handshake/reset: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Assert reset during NORM -> next cycle out_valid=0, in_ready=1. A new input then completes normally.
